// File: rtl/periph_pkg.sv
// Shared peripheral definitions: register offsets, TCON bit positions and the
// default window base used by the memory-mapped timer.
package periph_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [3:0] TH_OFF   = 4'h0;
    localparam logic [3:0] TL_OFF   = 4'h4;
    localparam logic [3:0] TCON_OFF = 4'h8;
    localparam logic [3:0] OVF_OFF  = 4'hC;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Word index within the 16-byte window (addr[3:2])
    typedef enum logic [1:0] {
        REG_TH   = TH_OFF[3:2],
        REG_TL   = TL_OFF[3:2],
        REG_TCON = TCON_OFF[3:2],
        REG_OVF  = OVF_OFF[3:2]
    } reg_sel_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/timer_irq_if.sv
// CPU-side load/store bus into the timer window, plus the interrupt line back
// to control.
interface timer_irq_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;

    modport master (output rd, output wr, output addr, output wdata,
                    input rdata, input irqout);
    modport slave  (input rd, input wr, input addr, input wdata,
                    output rdata, output irqout);
endinterface

// File: rtl/timer_irq_prescaler.sv
// Clock-cycle prescaler: pcnt runs 0..PRESCALE-1 while enabled and tick marks
// the last cycle of each period.
module prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == LAST);

    // Period counter; disabled timer parks it at zero so re-enabling starts a full period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (!en) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer: TH/TL/TCON/OVF register file, address decode,
// combinational read mux and the interrupt request to the CPU.
module timer_irq
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus
);
    logic [31:0] th_r, tl_r;
    logic [7:0]  ovf_r;
    logic        en_r, ie_r, is_r;

    logic [31:0] th_nxt_s, tl_nxt_s, rdata_s;
    logic [7:0]  ovf_nxt_s;
    logic        en_nxt_s, ie_nxt_s, is_nxt_s;
    logic        hit_s, wen_s, tick_s, step_s, wrap_s;
    logic        addr_unused_s;
    reg_sel_e    sel_s;

    prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_r),
        .tick  (tick_s)
    );

    assign hit_s         = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wen_s         = bus.wr & hit_s;
    assign sel_s         = reg_sel_e'(bus.addr[3:2]);
    assign addr_unused_s = ^bus.addr[1:0];
    assign step_s        = en_r & tick_s;
    assign wrap_s        = step_s & (tl_r == 32'hFFFF_FFFF);

    // Next-state: count step first, then software writes override, then IS set has final say
    always_comb begin
        th_nxt_s  = th_r;
        tl_nxt_s  = tl_r;
        ovf_nxt_s = ovf_r;
        en_nxt_s  = en_r;
        ie_nxt_s  = ie_r;
        is_nxt_s  = is_r;

        if (wrap_s) begin
            tl_nxt_s  = th_r;
            ovf_nxt_s = sat_inc8(ovf_r);
        end else if (step_s) begin
            tl_nxt_s  = tl_r + 32'd1;
        end else begin
            tl_nxt_s  = tl_r;
        end

        if (wen_s) begin
            case (sel_s)
                REG_TH:   th_nxt_s = bus.wdata;
                REG_TL:   tl_nxt_s = bus.wdata;
                REG_TCON: begin
                    en_nxt_s = bus.wdata[TCON_EN];
                    ie_nxt_s = bus.wdata[TCON_IE];
                    if (!bus.wdata[TCON_IS]) begin
                        is_nxt_s = 1'b0;
                    end else begin
                        is_nxt_s = is_r;
                    end
                end
                REG_OVF:  ovf_nxt_s = 8'h00;
                default:  th_nxt_s = th_r;
            endcase
        end else begin
            th_nxt_s = th_r;
        end

        if (wrap_s && ie_r) begin
            is_nxt_s = 1'b1;
        end else begin
            is_nxt_s = is_nxt_s;
        end
    end

    // Register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_r  <= 32'h0;
            tl_r  <= 32'h0;
            ovf_r <= 8'h00;
            en_r  <= 1'b0;
            ie_r  <= 1'b0;
            is_r  <= 1'b0;
        end else begin
            th_r  <= th_nxt_s;
            tl_r  <= tl_nxt_s;
            ovf_r <= ovf_nxt_s;
            en_r  <= en_nxt_s;
            ie_r  <= ie_nxt_s;
            is_r  <= is_nxt_s;
        end
    end

    // Read mux; outside the window or without rd the bus contribution is zero
    always_comb begin
        rdata_s = 32'h0;
        if (bus.rd && hit_s) begin
            case (sel_s)
                REG_TH:   rdata_s = th_r;
                REG_TL:   rdata_s = tl_r;
                REG_TCON: rdata_s = {29'h0, is_r, ie_r, en_r};
                REG_OVF:  rdata_s = {24'h0, ovf_r};
                default:  rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign bus.rdata  = rdata_s;
    assign bus.irqout = ie_r & is_r;

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped interval timer that sits directly upstream of the single-cycle CPU's interrupt input. It is addressed through the CPU's ALU result and store-data buses during `lw`/`sw`. It reloads a 32-bit count from a programmable reload value and raises `irqout`, which the CPU's control unit samples to vector to the exception handler at 0x80000004. It also keeps a saturating overflow tally so software can detect missed interrupts.

## Interface
- `BASE_ADDR`, 32'h4000_0000: base of the 16-byte register window.
- `PRESCALE`, 1: clk cycles per count step (≥1).
- `clk`  in  1: CPU clock (divided clock, same domain as PC/RegisterFile).
- `reset`  in  1: asynchronous, active-low reset.
- `rd`  in  1: MemRead from control.
- `wr`  in  1: MemWrite from control.
- `addr`  in  32: ALU result (byte address).
- `wdata`  in  32: store data (rt).
- `rdata`  out  32: read data; combinational.
- `irqout`  out  1: interrupt request to control.

## Operation
- Registers, all word-aligned; `addr[1:0]` is ignored:
  - TH at BASE+0x0: reload value, R/W.
  - TL at BASE+0x4: counter, R/W.
  - TCON at BASE+0x8: bit0 EN, bit1 IE, bit2 IS; bits 31:3 read 0.
  - OVF at BASE+0xC: 8-bit saturating overflow count, zero-extended on read; any write clears it.
- Hit = `addr[31:4] == BASE_ADDR[31:4]`.
- Read path: `rdata` = selected register when `rd` && hit, else 32'h0. Reads have no side effects.
- Prescaler: counter `pcnt`, width $clog2(PRESCALE)+1.
  - Counts 0..PRESCALE-1 while EN=1.
  - `tick` is asserted when `pcnt==PRESCALE-1`, and `pcnt` wraps to 0 on that cycle.
  - EN=0 holds `pcnt` at 0.
- Count step (EN && tick):
  - If TL == 32'hFFFF_FFFF: TL <= TH; OVF <= OVF+1, saturating at 8'hFF; if IE, IS <= 1.
  - Else TL <= TL+1, 32-bit unsigned.
- `irqout` = IE & IS, combinational from registers.
- Software acknowledges by writing TCON with bit2=0. Writing bit2=1 leaves IS unchanged; software cannot set IS.
- Simultaneous events in one cycle, with the required priority:
  - Write to TL and count step: the written value wins and the step is lost.
  - Write to TH and overflow: TL reloads from the old TH; the new TH takes effect from the next cycle.
  - TCON write clearing IS and overflow setting IS: set wins, so IS=1 and no interrupt is lost.
  - TCON write clearing EN and tick: the step still happens this cycle, then counting stops.
  - OVF write and overflow: OVF <= 0. The clear wins and this overflow is not tallied.
- Writes only when `wr` && hit; `rd` and `wr` together are treated as a write plus a read of the old value.

## Timing
- Reset (async, `reset`=0): TH=0, TL=0, TCON=0, OVF=0, `pcnt`=0. Outputs: `irqout`=0; `rdata`=0 (since `rd`=0 in reset).
- Register updates occur on posedge `clk`.
- A `sw` to any register is visible to a `lw` in the next instruction (next cycle).
- Overflow to `irqout`: `irqout` rises one clk after the edge that sees TL==FFFF_FFFF with tick, i.e. in the same cycle TL shows TH.
- Period: (2^32 − TH) × PRESCALE cycles between consecutive overflows.
- Reset asserted mid-count clears everything immediately; no pending IRQ survives.

## Structure
- Shared package `periph_pkg`: register offsets (TH_OFF=4'h0, TL_OFF=4'h4, TCON_OFF=4'h8, OVF_OFF=4'hC), TCON bit indices (EN=0, IE=1, IS=2), default BASE_ADDR.
- One sub-module: `prescaler`, which holds `pcnt` and produces `tick`.
- `timer_irq` holds the register file, the decode and the read mux.
- The block instantiates inside Peripheral; Peripheral ORs its `rdata` into the shared read bus.

## Test plan
- Reset: with `reset`=0, every register reads 0 and `irqout`=0.
- Overflow and reload: write TH=FFFF_FFFC, TL=FFFF_FFFC, TCON=3 (PRESCALE=1) → TL steps FD, FE, FF; on the next edge TL=FFFF_FFFC, IS=1, `irqout`=1 and OVF=1. The second overflow follows 4 cycles later.
- Acknowledge and race:
  - Write TCON=3 while idle → IS cleared and `irqout` drops next cycle.
  - Repeat with the write landing on the overflow edge → IS stays 1.
- Prescaler: PRESCALE=4, TL=0, EN=1 → TL=1 after 4 cycles and 5 after 20. Clearing EN at cycle 6 freezes TL=1, and `pcnt` returns to 0.
- IE masked: TCON=1 with overflow → IS stays 0 and `irqout`=0, but OVF increments. After 256 overflows OVF reads 0000_00FF; a write to OVF reads back 0.
- Decode: `lw` from BASE+0x10 or 0x3FFF_FFF8 → `rdata`=0. A `sw` there leaves all registers unchanged; a `sw` with `addr[1:0]`=2'b11 to BASE+0x7 writes TL.
